morse_key_classifier: RTL

- Upstream front-end of the Morse decoder in tt_um_morse_code; sits between the raw key input (ui_in[0]) and the symbol-to-character decoder.
- Synchronises and debounces the key, then measures press and gap durations in coarse ticks.
- Emits one-cycle events: dot/dash symbol, character end, word end.
- The decoder consumes only these events; it never sees the raw key.

---
 rtl/morse_pkg.sv | 28 ++
 rtl/morse_debounce.sv | 48 ++++
 rtl/morse_key_classifier.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse key front-end and the downstream decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_WGAP  = 2'd3
    } morse_state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int unsigned TICK_DIV_DEF        = 1000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned DASH_MIN_TICKS_DEF  = 20;
    localparam int unsigned CHAR_GAP_TICKS_DEF  = 30;
    localparam int unsigned WORD_GAP_TICKS_DEF  = 70;
    localparam int unsigned CNT_W_DEF           = 8;
    localparam int unsigned MIN_PRESS_TICKS_DEF = 3;
    localparam int unsigned SYM_COUNT_W         = 3;

    // Symbols-per-character count sticks at its maximum instead of wrapping.
    function automatic logic [SYM_COUNT_W-1:0] sym_count_inc(input logic [SYM_COUNT_W-1:0] c);
        return (c == '1) ? c : c + SYM_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser plus stability counter; level changes only after a run of
// DEBOUNCE_CYCLES identical samples that differ from the current level.
module morse_debounce
    import morse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_edge_c
);

    localparam int unsigned STAB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic              r_sync0;
    logic              r_sync1;
    logic              r_level;
    logic [STAB_W-1:0] r_stab;
    logic              w_mismatch;

    assign w_mismatch = (r_sync1 != r_level);
    // Strobe is combinational so the consumer can react on the same edge the level flips.
    assign o_edge_c   = w_mismatch && (r_stab == STAB_W'(DEBOUNCE_CYCLES - 1));
    assign o_level    = r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_stab  <= '0;
        end else begin
            r_sync0 <= i_key;
            r_sync1 <= r_sync0;
            if (o_edge_c) begin
                r_level <= r_sync1;
                r_stab  <= '0;
            end else if (w_mismatch) begin
                r_stab  <= r_stab + STAB_W'(1);
            end else begin
                r_stab  <= '0;
            end
        end
    end

endmodule

// File: rtl/morse_key_classifier.sv
// Debounced Morse key timing classifier: dot/dash, character-end and word-end events.
// Optional MORSE_GLITCH_REJECT_EN drops presses shorter than MIN_PRESS_TICKS.
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DASH_MIN_TICKS  = DASH_MIN_TICKS_DEF,
    parameter int unsigned CHAR_GAP_TICKS  = CHAR_GAP_TICKS_DEF,
    parameter int unsigned WORD_GAP_TICKS  = WORD_GAP_TICKS_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
`ifdef MORSE_GLITCH_REJECT_EN
    ,
    parameter int unsigned MIN_PRESS_TICKS = MIN_PRESS_TICKS_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_in,
    output logic                   key_level,
    output logic                   sym_valid,
    output logic                   sym_is_dash,
    output logic                   char_end,
    output logic                   word_end,
    output logic [SYM_COUNT_W-1:0] sym_count
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV + 1);

    logic                   w_level;
    logic                   w_edge_c;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_tick;
    logic [PRESC_W-1:0]     r_presc;

    morse_state_t           r_state;
    morse_state_t           w_state_nxt;
    logic [CNT_W-1:0]       r_press_ticks;
    logic [CNT_W-1:0]       r_gap_ticks;
    logic [CNT_W-1:0]       w_press_nxt;
    logic [CNT_W-1:0]       w_gap_nxt;
    logic [CNT_W-1:0]       w_press_inc;
    logic [CNT_W-1:0]       w_gap_inc;
    logic                   w_is_dash;
    logic                   r_sym_valid;
    logic                   r_sym_is_dash;
    logic                   r_char_end;
    logic                   r_word_end;
    logic [SYM_COUNT_W-1:0] r_sym_count;
    logic                   w_sym_valid_nxt;
    logic                   w_is_dash_nxt;
    logic                   w_char_end_nxt;
    logic                   w_word_end_nxt;
    logic [SYM_COUNT_W-1:0] w_sym_count_nxt;
`ifdef MORSE_GLITCH_REJECT_EN
    morse_state_t           r_ret_state;
    morse_state_t           w_ret_nxt;
    logic [CNT_W-1:0]       r_gap_save;
    logic [CNT_W-1:0]       w_gap_save_nxt;
    logic                   w_glitch;
`endif

    morse_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (key_in),
        .o_level (w_level),
        .o_edge_c(w_edge_c)
    );

    assign w_rise = w_edge_c && !w_level;
    assign w_fall = w_edge_c &&  w_level;
    assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

    // Prescaler restarts on every accepted key edge so durations are edge-aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_edge_c || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Counter values including this cycle's tick, so the edge-cycle tick is not lost.
    assign w_press_inc = w_tick ? sat_inc(r_press_ticks) : r_press_ticks;
    assign w_gap_inc   = w_tick ? sat_inc(r_gap_ticks)   : r_gap_ticks;
    assign w_is_dash   = (32'(w_press_inc) >= DASH_MIN_TICKS);
`ifdef MORSE_GLITCH_REJECT_EN
    assign w_glitch    = (32'(w_press_inc) < MIN_PRESS_TICKS);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_press_ticks <= '0;
            r_gap_ticks   <= '0;
            r_sym_valid   <= 1'b0;
            r_sym_is_dash <= 1'b0;
            r_char_end    <= 1'b0;
            r_word_end    <= 1'b0;
            r_sym_count   <= '0;
`ifdef MORSE_GLITCH_REJECT_EN
            r_ret_state   <= ST_IDLE;
            r_gap_save    <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_press_ticks <= w_press_nxt;
            r_gap_ticks   <= w_gap_nxt;
            r_sym_valid   <= w_sym_valid_nxt;
            r_sym_is_dash <= w_is_dash_nxt;
            r_char_end    <= w_char_end_nxt;
            r_word_end    <= w_word_end_nxt;
            r_sym_count   <= w_sym_count_nxt;
`ifdef MORSE_GLITCH_REJECT_EN
            r_ret_state   <= w_ret_nxt;
            r_gap_save    <= w_gap_save_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_press_nxt     = r_press_ticks;
        w_gap_nxt       = r_gap_ticks;
        w_sym_valid_nxt = 1'b0;
        w_is_dash_nxt   = r_sym_is_dash;
        w_char_end_nxt  = 1'b0;
        w_word_end_nxt  = 1'b0;
        w_sym_count_nxt = r_char_end ? '0 : r_sym_count;
`ifdef MORSE_GLITCH_REJECT_EN
        w_ret_nxt       = r_ret_state;
        w_gap_save_nxt  = r_gap_save;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESS;
                    w_press_nxt = '0;
`ifdef MORSE_GLITCH_REJECT_EN
                    w_ret_nxt      = ST_IDLE;
                    w_gap_save_nxt = '0;
`endif
                end
            end
            ST_PRESS: begin
                w_press_nxt = w_press_inc;
                if (w_fall) begin
                    w_state_nxt     = ST_GAP;
                    w_gap_nxt       = '0;
                    w_sym_valid_nxt = 1'b1;
                    w_is_dash_nxt   = w_is_dash ? SYM_DASH : SYM_DOT;
                    w_sym_count_nxt = sym_count_inc(r_sym_count);
`ifdef MORSE_GLITCH_REJECT_EN
                    // Too short to be a symbol: resume exactly where the gap left off.
                    if (w_glitch) begin
                        w_state_nxt     = r_ret_state;
                        w_gap_nxt       = r_gap_save;
                        w_sym_valid_nxt = 1'b0;
                        w_is_dash_nxt   = r_sym_is_dash;
                        w_sym_count_nxt = r_sym_count;
                    end
`endif
                end
            end
            ST_GAP: begin
                w_gap_nxt = w_gap_inc;
                // A rise on the threshold tick still closes the character, then opens a new one.
                if (32'(w_gap_inc) >= CHAR_GAP_TICKS) begin
                    w_char_end_nxt = 1'b1;
                    w_state_nxt    = w_rise ? ST_PRESS : ST_WGAP;
`ifdef MORSE_GLITCH_REJECT_EN
                    w_ret_nxt      = ST_IDLE;
                    w_gap_save_nxt = '0;
`endif
                end else if (w_rise) begin
                    w_state_nxt = ST_PRESS;
`ifdef MORSE_GLITCH_REJECT_EN
                    w_ret_nxt      = ST_GAP;
                    w_gap_save_nxt = w_gap_inc;
`endif
                end
                if (w_rise) begin
                    w_press_nxt = '0;
                end
            end
            ST_WGAP: begin
                w_gap_nxt = w_gap_inc;
                if (32'(w_gap_inc) >= WORD_GAP_TICKS) begin
                    w_word_end_nxt = 1'b1;
                    w_state_nxt    = w_rise ? ST_PRESS : ST_IDLE;
`ifdef MORSE_GLITCH_REJECT_EN
                    w_ret_nxt      = ST_IDLE;
                    w_gap_save_nxt = '0;
`endif
                end else if (w_rise) begin
                    w_state_nxt = ST_PRESS;
`ifdef MORSE_GLITCH_REJECT_EN
                    w_ret_nxt      = ST_WGAP;
                    w_gap_save_nxt = w_gap_inc;
`endif
                end
                if (w_rise) begin
                    w_press_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign key_level   = w_level;
    assign sym_valid   = r_sym_valid;
    assign sym_is_dash = r_sym_is_dash;
    assign char_end    = r_char_end;
    assign word_end    = r_word_end;
    assign sym_count   = r_sym_count;

endmodule
